// File: rtl/coef_word_packer_if.sv
// rtl/coef_word_packer_if.sv - coefficient stream handshake bundle for coef_word_packer
interface coef_word_packer_if #(
    parameter int COEF_WIDTH = 16
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [COEF_WIDTH-1:0] in_coef;
    logic                  in_last;

    // Coefficient source (NTT/arith datapath side)
    modport master (
        output in_valid,
        output in_coef,
        output in_last,
        input  in_ready
    );

    // Packer side
    modport slave (
        input  in_valid,
        input  in_coef,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/coef_word_packer.sv
// rtl/coef_word_packer.sv - packs narrow coefficients into wide FIFO words with pad-and-flush on last
module coef_word_packer #(
    parameter int COEF_WIDTH = 16,
    parameter int WORD_WIDTH = 64,
    parameter int PAD_VALUE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_en,
    coef_word_packer_if.slave     in_if,
    input  logic                  fifo_full,
    output logic                  fifo_enqueue_en,
    output logic [WORD_WIDTH-1:0] fifo_value,
    output logic                  poly_done,
    output logic [15:0]           words_enq
);
    localparam int LANES = WORD_WIDTH / COEF_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [COEF_WIDTH-1:0] PAD_LANE = COEF_WIDTH'(PAD_VALUE);
    localparam logic [WORD_WIDTH-1:0] PAD_WORD = {LANES{PAD_LANE}};
    localparam logic [LW-1:0]         LAST_LANE = LW'(LANES - 1);

    if ((WORD_WIDTH % COEF_WIDTH) != 0 || LANES < 2) begin : g_bad_params
        $error("coef_word_packer: WORD_WIDTH must be a multiple of COEF_WIDTH with at least 2 lanes");
    end

    logic [WORD_WIDTH-1:0] acc;
    logic [LW-1:0]         lane;
    logic [WORD_WIDTH-1:0] out_word;
    logic                  out_valid;
    logic                  out_last;

    logic                  xfer;
    logic                  closing;
    logic [WORD_WIDTH-1:0] next_word;

    // Output slot is free, or it drains into the FIFO this very cycle.
    assign in_if.in_ready  = !out_valid || !fifo_full;
    assign xfer            = in_if.in_valid && in_if.in_ready;
    assign closing         = (lane == LAST_LANE) || in_if.in_last;

    assign fifo_enqueue_en = out_valid && !fifo_full && !flush_en;
    assign fifo_value      = out_word;
    assign poly_done       = fifo_enqueue_en && out_last;

    // Insert the incoming coefficient into the current lane; higher lanes already hold PAD.
    always_comb begin
        next_word = acc;
        next_word[lane*COEF_WIDTH +: COEF_WIDTH] = in_if.in_coef;
    end

    // Accumulator, output slot and enqueue counter; flush_en outranks every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= PAD_WORD;
            lane      <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            words_enq <= 16'd0;
        end else if (flush_en) begin
            acc       <= PAD_WORD;
            lane      <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            words_enq <= 16'd0;
        end else begin
            if (fifo_enqueue_en) begin
                words_enq <= words_enq + 16'd1;
            end
            if (xfer && closing) begin
                // A fresh word replaces a draining one, so out_valid never bubbles.
                out_word  <= next_word;
                out_valid <= 1'b1;
                out_last  <= in_if.in_last;
                acc       <= PAD_WORD;
                lane      <= '0;
            end else begin
                if (xfer) begin
                    acc  <= next_word;
                    lane <= lane + LW'(1);
                end
                if (fifo_enqueue_en) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end
        end
    end

    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_enqueue_en && fifo_full));

endmodule

// File: tb/tb_coef_word_packer.sv
// tb/tb_coef_word_packer.sv - scoreboard bench for coef_word_packer (PAD 0 and PAD 7 instances)
module tb_coef_word_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_en;
    logic        fifo_full;

    logic        en_a, en_b, pd_a, pd_b;
    logic [63:0] val_a, val_b;
    logic [15:0] cnt_a, cnt_b;

    coef_word_packer_if #(.COEF_WIDTH(16)) ifa ();
    coef_word_packer_if #(.COEF_WIDTH(16)) ifb ();

    coef_word_packer #(.COEF_WIDTH(16), .WORD_WIDTH(64), .PAD_VALUE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_en(flush_en), .in_if(ifa),
        .fifo_full(fifo_full), .fifo_enqueue_en(en_a), .fifo_value(val_a),
        .poly_done(pd_a), .words_enq(cnt_a)
    );

    coef_word_packer #(.COEF_WIDTH(16), .WORD_WIDTH(64), .PAD_VALUE(7)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_en(flush_en), .in_if(ifb),
        .fifo_full(fifo_full), .fifo_enqueue_en(en_b), .fifo_value(val_b),
        .poly_done(pd_b), .words_enq(cnt_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int stalls  = 0;
    int pd_cnt  = 0;
    bit rec     = 1'b0;
    int enq_cyc[$];

    logic [15:0] cur[$];
    logic [64:0] q_a[$];   // {last, word}
    logic [64:0] q_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] pad);
        logic [63:0] w;
        for (int i = 0; i < 4; i++) begin
            w[i*16 +: 16] = (i < cur.size()) ? cur[i] : pad;
        end
        return w;
    endfunction

    task automatic model_push(input logic [15:0] c, input logic last);
        cur.push_back(c);
        if (cur.size() == 4 || last) begin
            q_a.push_back({last, pack(16'h0000)});
            q_b.push_back({last, pack(16'h0007)});
            cur.delete();
        end
    endtask

    task automatic model_clear();
        cur.delete();
        q_a.delete();
        q_b.delete();
    endtask

    task automatic send(input logic [15:0] c, input logic last);
        int waited = 0;
        ifa.in_valid = 1'b1; ifa.in_coef = c; ifa.in_last = last;
        ifb.in_valid = 1'b1; ifb.in_coef = c; ifb.in_last = last;
        @(negedge clk);
        while (!ifa.in_ready && waited < 50) begin
            waited++;
            stalls++;
            @(negedge clk);
        end
        if (!ifa.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for coef 0x%0h", c);
        end else begin
            @(posedge clk);
            #1;
            model_push(c, last);
        end
        ifa.in_valid = 1'b0; ifa.in_last = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    // Monitor: pops the scoreboard whenever either packer enqueues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (en_a || en_b) begin
                check("enq_align", {63'd0, en_b}, {63'd0, en_a});
                if (q_a.size() == 0 || q_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_enq: got 0x%0h with no word expected", val_a);
                end else begin
                    logic [64:0] ea, eb;
                    ea = q_a.pop_front();
                    eb = q_b.pop_front();
                    check("word_pad0", val_a, ea[63:0]);
                    check("word_pad7", val_b, eb[63:0]);
                    check("poly_done", {62'd0, pd_b, pd_a}, {62'd0, eb[64], ea[64]});
                end
                if (rec) enq_cyc.push_back(cyc);
                if (pd_a) pd_cnt++;
            end
        end
    end

    initial begin
        int c0;
        rst_n = 1'b0; flush_en = 1'b0; fifo_full = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_coef = '0; ifa.in_last = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_coef = '0; ifb.in_last = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // 1: reset values, then one full word
        @(negedge clk);
        check("rst_in_ready", {63'd0, ifa.in_ready}, 64'd1);
        check("rst_enq_en", {63'd0, en_a}, 64'd0);
        check("rst_value", val_a, 64'd0);
        check("rst_poly_done", {63'd0, pd_a}, 64'd0);
        check("rst_words_enq", {48'd0, cnt_a}, 64'd0);
        @(posedge clk); #1;
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        send(16'h3333, 1'b0);
        send(16'h4444, 1'b0);
        @(negedge clk);
        check("t1_enq_en", {63'd0, en_a}, 64'd1);
        check("t1_value", val_a, 64'h4444_3333_2222_1111);
        @(posedge clk); #1;
        check("t1_words_enq", {48'd0, cnt_a}, 64'd1);

        // 2: partial word closed by in_last, padded
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b1);
        @(negedge clk);
        check("t2_value_pad0", val_a, 64'h0000_0000_BBBB_AAAA);
        check("t2_value_pad7", val_b, 64'h0007_0007_BBBB_AAAA);
        check("t2_poly_done", {62'd0, pd_b, pd_a}, 64'd3);
        @(posedge clk); #1;

        // 3: backpressure holds the pending word
        fifo_full = 1'b1;
        send(16'h0101, 1'b0);
        send(16'h0202, 1'b0);
        send(16'h0303, 1'b0);
        send(16'h0404, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_ready_full", {63'd0, ifa.in_ready}, 64'd0);
            check("t3_enq_full", {63'd0, en_a}, 64'd0);
            check("t3_value_hold", val_a, 64'h0404_0303_0202_0101);
        end
        @(posedge clk); #1;
        fifo_full = 1'b0;
        @(negedge clk);
        check("t3_enq_release", {63'd0, en_a}, 64'd1);
        check("t3_ready_release", {63'd0, ifa.in_ready}, 64'd1);
        @(posedge clk); #1;

        // 4: 64 coefficients back-to-back
        do_reset();
        stalls = 0; pd_cnt = 0; rec = 1'b1; enq_cyc.delete();
        for (int i = 0; i < 64; i++) send(16'(i * 3 + 1), i == 63);
        idle(3);
        rec = 1'b0;
        check("t4_stalls", 64'(stalls), 64'd0);
        check("t4_enq_count", 64'(enq_cyc.size()), 64'd16);
        check("t4_words_enq", {48'd0, cnt_a}, 64'd16);
        check("t4_poly_done_cnt", 64'(pd_cnt), 64'd1);
        for (int i = 1; i < enq_cyc.size(); i++)
            check("t4_spacing", 64'(enq_cyc[i] - enq_cyc[i-1]), 64'd4);

        // 5: flush discards a partial word
        do_reset();
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        flush_en = 1'b1;
        idle(1);
        flush_en = 1'b0;
        cur.delete();
        send(16'h0005, 1'b0);
        send(16'h0006, 1'b0);
        send(16'h0007, 1'b0);
        send(16'h0008, 1'b0);
        @(negedge clk);
        check("t5_value", val_a, 64'h0008_0007_0006_0005);
        idle(3);
        check("t5_words_enq", {48'd0, cnt_a}, 64'd1);

        // 6: async reset while a word is pending against a full FIFO
        fifo_full = 1'b1;
        send(16'h00A1, 1'b0);
        send(16'h00A2, 1'b0);
        send(16'h00A3, 1'b0);
        send(16'h00A4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_enq_in_reset", {63'd0, en_a}, 64'd0);
        check("t6_ready_in_reset", {63'd0, ifa.in_ready}, 64'd1);
        model_clear();
        idle(2);
        rst_n = 1'b1;
        fifo_full = 1'b0;
        c0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (en_a) c0++;
        end
        check("t6_no_enq_after_release", 64'(c0), 64'd0);
        @(posedge clk); #1;
        send(16'h00C1, 1'b0);
        send(16'h00C2, 1'b0);
        send(16'h00C3, 1'b0);
        send(16'h00C4, 1'b0);
        @(negedge clk);
        check("t6_enq_new", {63'd0, en_a}, 64'd1);
        idle(3);
        check("t6_words_enq", {48'd0, cnt_a}, 64'd1);

        check("sb_empty_a", 64'(q_a.size()), 64'd0);
        check("sb_empty_b", 64'(q_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
